// File: rtl/qu_rob_pkg.sv
// Shared Qu core types for the reorder buffer: entry layout, tag type and default widths.
package qu_common;

    localparam int QU_PC_WIDTH       = 32;
    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int QU_DATA_WIDTH     = 32;
    localparam int QU_ROB_DEPTH      = 16;
    localparam int QU_ROB_AW         = $clog2(QU_ROB_DEPTH);

    typedef logic [QU_ROB_AW-1:0] rob_tag_t;

    typedef struct packed {
        logic                         valid;
        logic                         done;
        logic [QU_PC_WIDTH-1:0]       pc;
        logic                         rd_en;
        logic [PHY_RF_ADDR_WIDTH-1:0] rd_addr;
        logic [QU_DATA_WIDTH-1:0]     data;
        logic                         redirect;
        logic [QU_PC_WIDTH-1:0]       target;
        logic                         exception;
    } rob_entry_t;

endpackage

// File: rtl/qu_rob.sv
// Reorder buffer: allocates entries in program order, accepts completions by tag,
// retires in order and flushes everything on a redirect or exception.
module qu_rob
    import qu_common::*;
#(
    parameter int   ROB_DEPTH     = QU_ROB_DEPTH,
    parameter int   PC_WIDTH      = QU_PC_WIDTH,
    parameter int   RF_ADDR_WIDTH = PHY_RF_ADDR_WIDTH,
    parameter int   DATA_WIDTH    = QU_DATA_WIDTH,
    localparam int  ROB_AW        = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [PC_WIDTH-1:0]      alloc_pc,
    input  logic                     alloc_rd_en,
    input  logic [RF_ADDR_WIDTH-1:0] alloc_rd_addr,
    output logic [ROB_AW-1:0]        alloc_tag,
    input  logic                     cpl_valid,
    input  logic [ROB_AW-1:0]        cpl_tag,
    input  logic [DATA_WIDTH-1:0]    cpl_data,
    input  logic                     cpl_redirect,
    input  logic [PC_WIDTH-1:0]      cpl_target,
    input  logic                     cpl_exception,
    output logic                     rf_wr_en,
    output logic [RF_ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [DATA_WIDTH-1:0]    rf_data_in,
    output logic                     branch,
    output logic                     exception,
    output logic [PC_WIDTH-1:0]      pc_override,
    output logic                     retire_valid,
    output logic [PC_WIDTH-1:0]      retire_pc,
    output logic [ROB_AW:0]          count
);

    typedef enum logic {ROB_RUN, ROB_FLUSH} rob_state_t;

    localparam logic [ROB_AW:0] DEPTH_C = (ROB_AW+1)'(ROB_DEPTH);

    rob_state_t          state;
    rob_state_t          state_n;
    logic [ROB_AW-1:0]   head;
    logic [ROB_AW-1:0]   tail;
    logic [ROB_AW:0]     count_n;
    rob_entry_t          entries [ROB_DEPTH];
    rob_entry_t          head_ent;
    logic                do_retire;
    logic                do_flush;
    logic                alloc_fire;
    logic                cpl_fire;

    // Ready depends only on registered state, so a same-cycle retire never frees a slot early.
    assign alloc_ready = (state == ROB_RUN) && (count < DEPTH_C);
    assign alloc_tag   = tail;

    always_comb begin
        head_ent   = entries[head];
        do_retire  = (state == ROB_RUN) && head_ent.valid && head_ent.done;
        do_flush   = do_retire && (head_ent.exception || head_ent.redirect);
        alloc_fire = alloc_valid && alloc_ready && !do_flush;
        cpl_fire   = cpl_valid && (state == ROB_RUN) &&
                     entries[cpl_tag].valid && !entries[cpl_tag].done;
        count_n    = count + (ROB_AW+1)'(alloc_fire) - (ROB_AW+1)'(do_retire);
        state_n    = ROB_RUN;
        if (do_flush) begin
            count_n = '0;
            state_n = ROB_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ROB_RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rf_wr_en     <= 1'b0;
            rf_rd_addr   <= '0;
            rf_data_in   <= '0;
            branch       <= 1'b0;
            exception    <= 1'b0;
            pc_override  <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            state <= state_n;
            count <= count_n;

            // Retire outputs are single-cycle pulses; idle cycles drive zeros.
            rf_wr_en     <= 1'b0;
            rf_rd_addr   <= '0;
            rf_data_in   <= '0;
            branch       <= 1'b0;
            exception    <= 1'b0;
            pc_override  <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            if (do_retire) begin
                if (head_ent.exception) begin
                    exception   <= 1'b1;
                    pc_override <= head_ent.pc;
                end else begin
                    retire_valid <= 1'b1;
                    retire_pc    <= head_ent.pc;
                    rf_wr_en     <= head_ent.rd_en;
                    rf_rd_addr   <= head_ent.rd_addr;
                    rf_data_in   <= head_ent.data;
                    if (head_ent.redirect) begin
                        branch      <= 1'b1;
                        pc_override <= head_ent.target;
                    end
                end
            end

            if (cpl_fire) begin
                entries[cpl_tag].done      <= 1'b1;
                entries[cpl_tag].data      <= cpl_data;
                entries[cpl_tag].redirect  <= cpl_redirect;
                entries[cpl_tag].target    <= cpl_target;
                entries[cpl_tag].exception <= cpl_exception;
            end

            if (alloc_fire) begin
                entries[tail].valid   <= 1'b1;
                entries[tail].done    <= 1'b0;
                entries[tail].pc      <= alloc_pc;
                entries[tail].rd_en   <= alloc_rd_en;
                entries[tail].rd_addr <= alloc_rd_addr;
                tail                  <= tail + 1'b1;
            end

            // A flush overrides every pointer and valid-bit update above.
            if (do_flush) begin
                head <= '0;
                tail <= '0;
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end else if (do_retire) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qu_rob.sv
// Randomized scoreboard bench for qu_rob: a program-order queue model predicts every retire event and status.
module tb_qu_rob;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_pc;
    logic        alloc_rd_en;
    logic [5:0]  alloc_rd_addr;
    logic [3:0]  alloc_tag;
    logic        cpl_valid;
    logic [3:0]  cpl_tag;
    logic [31:0] cpl_data;
    logic        cpl_redirect;
    logic [31:0] cpl_target;
    logic        cpl_exception;
    logic        rf_wr_en;
    logic [5:0]  rf_rd_addr;
    logic [31:0] rf_data_in;
    logic        branch;
    logic        exception;
    logic [31:0] pc_override;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [4:0]  count;

    qu_rob dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_rd_en(alloc_rd_en), .alloc_rd_addr(alloc_rd_addr), .alloc_tag(alloc_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
        .cpl_redirect(cpl_redirect), .cpl_target(cpl_target), .cpl_exception(cpl_exception),
        .rf_wr_en(rf_wr_en), .rf_rd_addr(rf_rd_addr), .rf_data_in(rf_data_in),
        .branch(branch), .exception(exception), .pc_override(pc_override),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        bit          rd_en;
        logic [5:0]  rd;
        logic [31:0] data;
        bit          done;
        bit          redir;
        bit          exc;
        logic [31:0] target;
    } uop_t;

    typedef struct {
        int          due;
        bit          rv;
        bit          rf;
        bit          br;
        bit          ex;
        logic [31:0] rpc;
        logic [5:0]  rd;
        logic [31:0] data;
        logic [31:0] ovr;
    } evt_t;

    uop_t q[$];
    evt_t evq[$];
    bit   m_flush;
    int   m_tail;
    int   ncyc;
    bit   mon_on;
    int   n_checks;
    int   n_fail;

    // Reference model: one call per clock edge, using the inputs presented in that cycle.
    task automatic model_step();
        bit   ready, ret, fl;
        uop_t u;
        evt_t e;
        ncyc++;
        if (rst) begin
            q.delete();
            m_flush = 0;
            m_tail  = 0;
            return;
        end
        ready = !m_flush && (q.size() < DEPTH);
        ret   = !m_flush && (q.size() > 0) && q[0].done;
        fl    = 0;
        if (ret) begin
            u  = q[0];
            fl = u.exc || u.redir;
            e  = '{due: ncyc, rv: 0, rf: 0, br: 0, ex: 0, rpc: 0, rd: 0, data: 0, ovr: 0};
            if (u.exc) begin
                e.ex  = 1;
                e.ovr = u.pc;
            end else begin
                e.rv   = 1;
                e.rpc  = u.pc;
                e.rf   = u.rd_en;
                e.rd   = u.rd;
                e.data = u.data;
                e.br   = u.redir;
                e.ovr  = u.target;
            end
            evq.push_back(e);
        end
        if (cpl_valid && !m_flush) begin
            foreach (q[i]) begin
                if (q[i].tag == int'(cpl_tag) && !q[i].done) begin
                    q[i].done   = 1;
                    q[i].data   = cpl_data;
                    q[i].redir  = cpl_redirect;
                    q[i].target = cpl_target;
                    q[i].exc    = cpl_exception;
                end
            end
        end
        if (ret) begin
            if (fl) begin
                q.delete();
                m_tail = 0;
            end else begin
                void'(q.pop_front());
            end
        end
        if (alloc_valid && ready && !fl) begin
            u = '{tag: m_tail, pc: alloc_pc, rd_en: alloc_rd_en, rd: alloc_rd_addr,
                  data: 0, done: 0, redir: 0, exc: 0, target: 0};
            q.push_back(u);
            m_tail = (m_tail + 1) % DEPTH;
        end
        m_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr_in();
        alloc_valid = 0; alloc_pc = 0; alloc_rd_en = 0; alloc_rd_addr = 0;
        cpl_valid = 0; cpl_tag = 0; cpl_data = 0; cpl_redirect = 0;
        cpl_target = 0; cpl_exception = 0;
    endtask

    task automatic idle(input int n);
        clr_in();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic alloc1(input logic [31:0] pc, input logic [5:0] rd);
        clr_in();
        alloc_valid = 1; alloc_pc = pc; alloc_rd_en = 1; alloc_rd_addr = rd;
        tick();
        clr_in();
    endtask

    task automatic cpl1(input int tag, input logic [31:0] d, input bit rdr,
                        input logic [31:0] tgt, input bit exc);
        clr_in();
        cpl_valid = 1; cpl_tag = 4'(tag); cpl_data = d;
        cpl_redirect = rdr; cpl_target = tgt; cpl_exception = exc;
        tick();
        clr_in();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: status every cycle, and retire events popped from the scoreboard when they appear.
    always @(negedge clk) begin
        if (mon_on) begin
            n_checks++;
            if (count !== 5'(q.size()) || alloc_tag !== 4'(m_tail) ||
                alloc_ready !== (!m_flush && q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL status cyc=%0d: count=%0d ready=%0b tag=%0d expected count=%0d ready=%0b tag=%0d",
                         ncyc, count, alloc_ready, alloc_tag, q.size(),
                         (!m_flush && q.size() < DEPTH), m_tail);
            end
            if (evq.size() > 0 && evq[0].due < ncyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_retire cyc=%0d: event due at cyc %0d never seen", ncyc, evq[0].due);
                void'(evq.pop_front());
            end
            if (retire_valid || rf_wr_en || branch || exception) begin
                n_checks++;
                if (evq.size() == 0 || evq[0].due != ncyc) begin
                    n_fail++;
                    $display("FAIL spurious_retire cyc=%0d: rv=%0b rf=%0b br=%0b ex=%0b expected no event",
                             ncyc, retire_valid, rf_wr_en, branch, exception);
                end else begin
                    evt_t e;
                    e = evq.pop_front();
                    if (retire_valid !== e.rv || rf_wr_en !== e.rf || branch !== e.br ||
                        exception !== e.ex ||
                        (e.rv && retire_pc !== e.rpc) ||
                        (e.rf && (rf_rd_addr !== e.rd || rf_data_in !== e.data)) ||
                        ((e.br || e.ex) && pc_override !== e.ovr)) begin
                        n_fail++;
                        $display("FAIL retire cyc=%0d: rv=%0b pc=%0h rf=%0b rd=%0d d=%0h br=%0b ex=%0b ovr=%0h expected rv=%0b pc=%0h rf=%0b rd=%0d d=%0h br=%0b ex=%0b ovr=%0h",
                                 ncyc, retire_valid, retire_pc, rf_wr_en, rf_rd_addr, rf_data_in,
                                 branch, exception, pc_override, e.rv, e.rpc, e.rf, e.rd, e.data,
                                 e.br, e.ex, e.ovr);
                    end
                end
            end else if (evq.size() > 0 && evq[0].due == ncyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_retire cyc=%0d: expected event not presented", ncyc);
                void'(evq.pop_front());
            end
        end
    end

    initial begin
        int pend[$];
        n_checks = 0; n_fail = 0; ncyc = 0; mon_on = 0;
        m_flush = 0; m_tail = 0;
        clr_in();
        rst = 1;
        tick();
        mon_on = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("reset_ready", 32'(alloc_ready), 1);
        chk("reset_count", 32'(count), 0);
        chk("reset_tag", 32'(alloc_tag), 0);
        chk("reset_pulses", {28'd0, retire_valid, rf_wr_en, branch, exception}, 0);
        rst = 0;
        idle(2);

        // Out-of-order completion, in-order writeback.
        alloc1(32'h10, 6'd5);
        alloc1(32'h14, 6'd6);
        alloc1(32'h18, 6'd7);
        cpl1(2, 32'hA, 0, 0, 0);
        cpl1(1, 32'hB, 0, 0, 0);
        cpl1(0, 32'hC, 0, 0, 0);
        chk("no_wb_yet", 32'(rf_wr_en), 0);
        tick();
        chk("wb0_addr", 32'(rf_rd_addr), 5);
        chk("wb0_data", rf_data_in, 32'hC);
        idle(4);

        // Fill to capacity, then retire one while dispatch keeps offering.
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < DEPTH; i++) alloc1(32'h200 + 32'(i * 4), 6'(i));
        chk("full_count", 32'(count), 16);
        chk("full_ready", 32'(alloc_ready), 0);
        alloc1(32'h300, 6'd40);
        alloc_valid = 1; alloc_pc = 32'h304; alloc_rd_en = 1; alloc_rd_addr = 6'd41;
        cpl_valid = 1; cpl_tag = 0; cpl_data = 32'h55;
        tick();
        cpl_valid = 0;
        tick();
        chk("full_retire_count", 32'(count), 15);
        chk("full_wrap_tag", 32'(alloc_tag), 0);
        tick();
        clr_in();
        for (int t = 1; t < DEPTH; t++) pend.push_back(t);
        pend.push_back(0);
        pend.shuffle();
        foreach (pend[i]) cpl1(pend[i], $urandom, 0, 0, 0);
        idle(20);

        // Redirect flush discards younger completed entries.
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 4; i++) alloc1(32'h80 + 32'(i * 4), 6'(10 + i));
        cpl1(1, 32'h84, 1, 32'h100, 0);
        cpl1(0, 32'h1, 0, 0, 0);
        cpl1(2, 32'h2, 0, 0, 0);
        cpl1(3, 32'h3, 0, 0, 0);
        idle(4);
        chk("redirect_count", 32'(count), 0);

        // Exception beats redirect.
        alloc1(32'h40, 6'd3);
        cpl1(0, 32'h9, 1, 32'h500, 1);
        tick();
        chk("exc_flag", 32'(exception), 1);
        chk("exc_branch", 32'(branch), 0);
        chk("exc_ovr", pc_override, 32'h40);
        idle(3);

        // Duplicate and stray completions.
        alloc1(32'h60, 6'd9);
        cpl1(5, 32'hDEAD, 0, 0, 0);
        cpl1(0, 32'h1, 0, 0, 0);
        cpl1(0, 32'h2, 0, 0, 0);
        chk("dup_data", rf_data_in, 32'h1);
        idle(3);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 4000; c++) begin
            clr_in();
            rst = ($urandom_range(0, 499) == 0);
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_pc = $urandom; alloc_rd_en = $urandom_range(0, 1); alloc_rd_addr = 6'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                int cand[$];
                foreach (q[i]) if (!q[i].done) cand.push_back(q[i].tag);
                cpl_valid = 1;
                cpl_tag = (cand.size() > 0 && $urandom_range(0, 7) != 0)
                        ? 4'(cand[$urandom_range(0, cand.size() - 1)]) : 4'($urandom);
                cpl_data = $urandom;
                cpl_redirect = ($urandom_range(0, 15) == 0);
                cpl_target = $urandom;
                cpl_exception = ($urandom_range(0, 31) == 0);
            end
            tick();
        end
        rst = 0;
        idle(4);
        chk("scoreboard_drained", 32'(evq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
